// File: rtl/multiplier_nbits.sv
// Digit-serial WIDTH x WIDTH multiplier: one DIGIT x DIGIT partial product per clock, START/PRONTO handshake.
// Optional two's-complement operands are enabled by defining MULT_SIGNED_EN.
module multiplier_nbits #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 START,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic [2*WIDTH-1:0]   result,
  output logic                 PRONTO,
  output logic                 BUSY
);
  localparam int ND = WIDTH / DIGIT;
  localparam int CW = (ND > 1) ? $clog2(ND) : 1;
  localparam logic [CW-1:0] LAST = CW'(ND - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   xr_q, xr_d, yr_q, yr_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, result_q, result_d;
  logic [CW-1:0]      i_q, i_d, j_q, j_d;
  logic               pronto_q, pronto_d;
  logic [WIDTH-1:0]   x_cap, y_cap;

  logic [DIGIT-1:0]   xd, yd;
  logic [2*DIGIT-1:0] pp;
  logic [2*WIDTH-1:0] pp_sh;

  assign xd    = xr_q[int'(i_q)*DIGIT +: DIGIT];
  assign yd    = yr_q[int'(j_q)*DIGIT +: DIGIT];
  assign pp    = (2*DIGIT)'(xd) * (2*DIGIT)'(yd);
  // i+j can exceed the counter width, so the shift amount is computed in int
  assign pp_sh = (2*WIDTH)'(pp) << (DIGIT * (int'(i_q) + int'(j_q)));

`ifdef MULT_SIGNED_EN
  logic sign_q, sign_d;
  assign x_cap  = x[WIDTH-1] ? -x : x;
  assign y_cap  = y[WIDTH-1] ? -y : y;
  assign sign_d = (state_q == S_IDLE && START) ? (x[WIDTH-1] ^ y[WIDTH-1]) : sign_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) sign_q <= 1'b0;
    else        sign_q <= sign_d;
  end
`else
  assign x_cap = x;
  assign y_cap = y;
`endif

  always_comb begin
    state_d  = state_q;
    xr_d     = xr_q;
    yr_d     = yr_q;
    acc_d    = acc_q;
    i_d      = i_q;
    j_d      = j_q;
    result_d = result_q;
    pronto_d = pronto_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          xr_d     = x_cap;
          yr_d     = y_cap;
          acc_d    = '0;
          i_d      = '0;
          j_d      = '0;
          pronto_d = 1'b0;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = acc_q + pp_sh;
        if (j_q == LAST) begin
          j_d = '0;
          if (i_q == LAST) state_d = S_DONE;
          else             i_d = i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      S_DONE: begin
`ifdef MULT_SIGNED_EN
        result_d = sign_q ? -acc_q : acc_q;
`else
        result_d = acc_q;
`endif
        pronto_d = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= S_IDLE;
      xr_q     <= '0;
      yr_q     <= '0;
      acc_q    <= '0;
      i_q      <= '0;
      j_q      <= '0;
      result_q <= '0;
      pronto_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      xr_q     <= xr_d;
      yr_q     <= yr_d;
      acc_q    <= acc_d;
      i_q      <= i_d;
      j_q      <= j_d;
      result_q <= result_d;
      pronto_q <= pronto_d;
    end
  end

  assign result = result_q;
  assign PRONTO = pronto_q;
  assign BUSY   = (state_q != S_IDLE);
endmodule

// File: tb/tb_multiplier_nbits.sv
// Scenario bench for multiplier_nbits: directed cases plus random operands against an arithmetic product model.
module tb_multiplier_nbits;
  localparam int WIDTH = 8;
  localparam int DIGIT = 4;
  localparam int ND    = WIDTH / DIGIT;
  localparam int LAT   = ND * ND + 1;

  logic               CLK = 1'b0;
  logic               RESET = 1'b0;
  logic               START = 1'b0;
  logic [WIDTH-1:0]   x = '0, y = '0;
  logic [2*WIDTH-1:0] result;
  logic               PRONTO, BUSY;

  int checks = 0;
  int passes = 0;

  multiplier_nbits #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .x(x), .y(y),
    .result(result), .PRONTO(PRONTO), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  function automatic logic [2*WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef MULT_SIGNED_EN
    return (2*WIDTH)'(longint'($signed(a)) * longint'($signed(b)));
`else
    return (2*WIDTH)'(longint'(a) * longint'(b));
`endif
  endfunction

  // Present operands with START for one edge; returns 1 time unit after the capture edge.
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    START = 1'b1; x = a; y = b;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  // Edges from the capture edge until PRONTO rises, bounded at 100.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge CLK); #1; n++;
    end while (!PRONTO && n < 100);
  endtask

  task automatic test_reset;
    RESET = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (result !== '0 || PRONTO !== 1'b0 || BUSY !== 1'b0)
      $display("FAIL reset_hold: result=%0h PRONTO=%b BUSY=%b, need 0/0/0", result, PRONTO, BUSY);
    else passes++;
    @(negedge CLK); RESET = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (result !== '0 || PRONTO !== 1'b0 || BUSY !== 1'b0)
      $display("FAIL reset_release: result=%0h PRONTO=%b BUSY=%b, need 0/0/0", result, PRONTO, BUSY);
    else passes++;
  endtask

  task automatic test_basic;
    int n, bc;
    start_op(8'd5, 8'd7);
    checks++;
    if (PRONTO !== 1'b0 || BUSY !== 1'b1)
      $display("FAIL basic_capture: PRONTO=%b BUSY=%b, need 0/1", PRONTO, BUSY);
    else passes++;
    n = 0; bc = 1;
    while (!PRONTO && n < 100) begin
      @(posedge CLK); #1; n++;
      if (BUSY) bc++;
    end
    checks++;
    if (n !== LAT) $display("FAIL basic_latency: got %0d edges, need %0d", n, LAT);
    else passes++;
    checks++;
    if (bc !== LAT) $display("FAIL basic_busy_cycles: got %0d, need %0d", bc, LAT);
    else passes++;
    checks++;
    if (result !== ref_mul(8'd5, 8'd7)) $display("FAIL basic_result: got %0d, need %0d", result, ref_mul(8'd5, 8'd7));
    else passes++;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (PRONTO !== 1'b1 || result !== ref_mul(8'd5, 8'd7) || BUSY !== 1'b0)
      $display("FAIL basic_hold: PRONTO=%b BUSY=%b result=%0d, need 1/0/%0d", PRONTO, BUSY, result, ref_mul(8'd5, 8'd7));
    else passes++;
  endtask

  task automatic test_boundary;
    int n;
    start_op(8'd255, 8'd255);
    wait_done(n);
    checks++;
    if (n !== LAT || result !== ref_mul(8'd255, 8'd255))
      $display("FAIL max_operands: got %0d after %0d edges, need %0d after %0d", result, n, ref_mul(8'd255, 8'd255), LAT);
    else passes++;
    @(posedge CLK); #1;
    start_op(8'd0, 8'd200);
    checks++;
    if (PRONTO !== 1'b0) $display("FAIL pronto_drop: PRONTO=%b, need 0", PRONTO);
    else passes++;
    wait_done(n);
    checks++;
    if (n !== LAT || result !== '0)
      $display("FAIL zero_operand: got %0d after %0d edges, need 0 after %0d", result, n, LAT);
    else passes++;
  endtask

  task automatic test_ignore_busy;
    int n;
    start_op(8'd12, 8'd13);
    START = 1'b1; x = 8'd3; y = 8'd3;
    repeat (2) @(posedge CLK);
    #1; START = 1'b0;
    wait_done(n);
    checks++;
    if (n !== LAT - 2 || result !== ref_mul(8'd12, 8'd13))
      $display("FAIL ignore_busy: got %0d after %0d more edges, need %0d after %0d", result, n, ref_mul(8'd12, 8'd13), LAT - 2);
    else passes++;
    @(posedge CLK); #1;
    checks++;
    if (BUSY !== 1'b0) $display("FAIL not_queued: BUSY=%b, need 0", BUSY);
    else passes++;
    start_op(8'd3, 8'd3);
    wait_done(n);
    checks++;
    if (result !== ref_mul(8'd3, 8'd3)) $display("FAIL after_ignore: got %0d, need %0d", result, ref_mul(8'd3, 8'd3));
    else passes++;
  endtask

  task automatic test_reset_mid;
    int n;
    @(posedge CLK); #1;
    start_op(8'd100, 8'd100);
    repeat (2) @(posedge CLK);
    #1; RESET = 1'b0;
    #1;
    checks++;
    if (result !== '0 || PRONTO !== 1'b0 || BUSY !== 1'b0)
      $display("FAIL reset_mid: result=%0h PRONTO=%b BUSY=%b, need 0/0/0", result, PRONTO, BUSY);
    else passes++;
    @(negedge CLK); RESET = 1'b1;
    @(posedge CLK); #1;
    start_op(8'd2, 8'd3);
    wait_done(n);
    checks++;
    if (n !== LAT || result !== ref_mul(8'd2, 8'd3))
      $display("FAIL after_reset: got %0d after %0d edges, need %0d after %0d", result, n, ref_mul(8'd2, 8'd3), LAT);
    else passes++;
  endtask

  task automatic test_back_to_back;
    int n;
    logic [WIDTH-1:0] a, b;
    a = WIDTH'($urandom); b = WIDTH'($urandom);
    START = 1'b1; x = a; y = b;
    @(posedge CLK); #1;
    wait_done(n);
    checks++;
    if (n !== LAT || result !== ref_mul(a, b))
      $display("FAIL b2b_first: got %0d after %0d edges, need %0d after %0d", result, n, ref_mul(a, b), LAT);
    else passes++;
    // START still high: the IDLE cycle after DONE takes the next operands
    a = WIDTH'($urandom); b = WIDTH'($urandom);
    x = a; y = b;
    @(posedge CLK); #1;
    START = 1'b0;
    checks++;
    if (PRONTO !== 1'b0 || BUSY !== 1'b1)
      $display("FAIL b2b_accept: PRONTO=%b BUSY=%b, need 0/1", PRONTO, BUSY);
    else passes++;
    wait_done(n);
    checks++;
    if (n !== LAT || result !== ref_mul(a, b))
      $display("FAIL b2b_second: got %0d after %0d edges, need %0d after %0d", result, n, ref_mul(a, b), LAT);
    else passes++;
  endtask

  task automatic test_random;
    int n;
    logic [WIDTH-1:0] a, b;
    for (int k = 0; k < 24; k++) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom);
      if (k == 3) a = '0;
      if (k == 5) begin a = '1; b = '1; end
      @(posedge CLK); #1;
      start_op(a, b);
      x = WIDTH'($urandom); y = WIDTH'($urandom);
      wait_done(n);
      checks++;
      if (n !== LAT || result !== ref_mul(a, b))
        $display("FAIL random_%0d: %0d*%0d got %0d after %0d edges, need %0d after %0d", k, a, b, result, n, ref_mul(a, b), LAT);
      else passes++;
    end
  endtask

`ifdef MULT_SIGNED_EN
  task automatic test_signed;
    int n;
    logic [WIDTH-1:0] av [3];
    logic [WIDTH-1:0] bv [3];
    av[0] = -WIDTH'(5);    bv[0] = WIDTH'(7);
    av[1] = {1'b1, {(WIDTH-1){1'b0}}}; bv[1] = av[1];
    av[2] = av[1];         bv[2] = WIDTH'(1);
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1;
      start_op(av[k], bv[k]);
      wait_done(n);
      checks++;
      if (result !== ref_mul(av[k], bv[k]))
        $display("FAIL signed_%0d: got %0h, need %0h", k, result, ref_mul(av[k], bv[k]));
      else passes++;
    end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_boundary;
    test_ignore_busy;
    test_reset_mid;
    test_back_to_back;
    test_random;
`ifdef MULT_SIGNED_EN
    test_signed;
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/multiplier_nbits.md
Name: multiplier_nbits

Overview:
- Parametrised successor of the 8-bit multiplier datapath.
- Datapath and control unit are merged into one block, so no external load/select strobes are needed.
- Operands are split into DIGIT-bit digits. One digit×digit partial product is accumulated per clock, shifted into position.
- Sits between a register-file/bus front end and consumers of a 2*WIDTH product. Uses a START/PRONTO handshake.

Parameters:
- WIDTH, 8, operand width in bits. Must be a multiple of DIGIT and ≥ DIGIT.
- DIGIT, 4, digit width per partial product. Legal values: 2, 4, 8.
- Derived, not a port: ND = WIDTH/DIGIT, the number of digits per operand.

Ports:
- CLK  in  1  clock; rising edge active.
- RESET  in  1  asynchronous, active-low reset (0 = reset).
- START  in  1  request; sampled on the rising edge of CLK.
- x  in  WIDTH  multiplicand; captured on an accepted START.
- y  in  WIDTH  multiplier; captured on an accepted START.
- result  out  2*WIDTH  product; registered, held stable until the next accepted START completes.
- PRONTO  out  1  high when result is valid.
- BUSY  out  1  high while a multiplication is in progress.

Behaviour:
- Reset (RESET=0, asynchronous): state=IDLE; result=0; PRONTO=0; BUSY=0; operand registers, accumulator and digit counters i, j cleared. Reset is honoured in any state, including mid-calculation; the partial product is discarded.
- State IDLE: BUSY=0. START=1 at an edge does all of the following, then moves to CALC:
  - captures x into XR and y into YR;
  - clears acc;
  - sets i=0, j=0;
  - sets PRONTO=0.
- State CALC: BUSY=1. Each edge does:
  - acc += (XR digit i * YR digit j) << (DIGIT*(i+j));
  - digit product width is 2*DIGIT; acc width is 2*WIDTH, and no overflow is possible for unsigned operands.
  - Iteration order: j is the inner loop (0..ND-1), i is the outer loop.
  - On the edge processing i=ND-1, j=ND-1, the next state is DONE.
- State DONE: held for one cycle. result <= acc; PRONTO <= 1; BUSY <= 0; next state is IDLE.
- PRONTO stays high in IDLE until the next accepted START, which clears it on the capture edge.
- Latency: START edge to PRONTO high is ND*ND + 1 edges. The default is 5 edges.
  - Throughput: one product per ND*ND + 2 cycles when START is held high.
- START while BUSY=1 (CALC or DONE): ignored, not queued. x and y may change freely during CALC without effect.
- START held high continuously: a new operation is accepted in the IDLE cycle following DONE.
- Boundary cases:
  - x=0 or y=0 gives result=0, and the full latency still applies.
  - Max operands, 2^WIDTH-1 each, give (2^WIDTH-1)^2 with no wrap.
- Counters i and j are max(1, clog2(ND)) bits wide. With ND=1 (DIGIT=WIDTH), CALC lasts exactly one cycle.

Optional Feature:
- Macro MULT_SIGNED_EN.
- Defined:
  - x and y are treated as two's complement.
  - On capture, XR and YR hold the magnitudes, and sign_r = x[WIDTH-1] ^ y[WIDTH-1].
  - In DONE, result = sign_r ? -acc : acc, 2*WIDTH two's complement.
  - The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which fits unsigned WIDTH bits, so it is handled correctly.
  - Latency is unchanged.
- Undefined: operands are unsigned. No sign logic is present.

Test Plan:
1. RESET=0 for 2 cycles, then release -> result=0, PRONTO=0, BUSY=0.
2. WIDTH=8, DIGIT=4: x=5, y=7, START pulsed 1 cycle -> BUSY high for 5 cycles; PRONTO=1 exactly 5 edges after START; result=35. PRONTO stays 1 until the next START.
3. x=255, y=255 -> result=65025. Then x=0, y=200 -> result=0 with the same latency, and PRONTO drops on the capture edge.
4. x=12, y=13 accepted; during CALC, START=1 with x=3, y=3 -> ignored; result=156. Then START again with x=3, y=3 -> result=9.
5. Assert RESET=0 two cycles into CALC of x=100, y=100 -> immediately result=0, PRONTO=0, state IDLE. A new START with x=2, y=3 -> result=6.
6. MULT_SIGNED_EN defined, WIDTH=8:
   - x=-5, y=7 -> result=16'hFFDD (-35);
   - x=-128, y=-128 -> result=16384;
   - x=-128, y=1 -> result=16'hFF80.
   - Also rerun with WIDTH=16, DIGIT=4 (ND=4): x=1000, y=3000 -> result=3000000 after 17 edges.
